hazard_fwd_sb: RTL

Parametrised operand hazard and forwarding unit with a long-latency register scoreboard. It sits between the register file read and the decode/issue stage. It resolves rs1/rs2 from STAGES in-flight pipeline stages and from out-of-band long-latency completions (divider, cache-miss loads). It raises a stall when an operand cannot be forwarded.

---
 rtl/hazard_fwd_sb_pkg.sv | 23 ++
 rtl/hazard_scoreboard.sv | 64 ++++++
 rtl/hazard_fwd_sb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_sb_pkg.sv
// Shared constants and types for the operand hazard / forwarding unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hazard_fwd_sb_pkg;

  localparam int XLEN           = 32;
  localparam int REG_AW         = 5;
  localparam int NREGS          = 1 << REG_AW;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  // Forwarding stage 0 is the youngest (EX); higher indices are older.
  localparam int STAGE_YOUNGEST = 0;

  // Result of resolving one source operand.
  typedef struct packed {
    logic [XLEN-1:0] d;
    logic            hz;
  } opnd_res_t;

  function automatic logic reg_nz(input logic [REG_AW-1:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Long-latency register scoreboard: busy bit per register plus outstanding-op counter.
// Latency: issue/done take effect on the busy vector and counter one cycle later.
// Backpressure: o_full when LL_DEPTH ops are outstanding; issue while full is ignored.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_ll_issue/_reg           long-latency op committed, destination register
//   i_ll_done/_reg            long-latency result returning, destination register
//   o_busy                    busy bit per register (bit 0 always 0)
//   o_full                    LL_DEPTH ops outstanding
module hazard_scoreboard
  import hazard_fwd_sb_pkg::*;
#(
  parameter int LL_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ll_issue,
  input  logic [REG_AW-1:0] i_ll_issue_reg,
  input  logic              i_ll_done,
  input  logic [REG_AW-1:0] i_ll_done_reg,
  output logic [NREGS-1:0]  o_busy,
  output logic              o_full
);

  localparam int CW = $clog2(LL_DEPTH + 1);

  logic [CW-1:0]    cnt;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             issue_ok;
  logic             done_ok;

  assign o_full   = (cnt == CW'(LL_DEPTH));
  // Issue while full and done with nothing outstanding are protocol errors; drop them.
  assign issue_ok = i_ll_issue && !o_full;
  assign done_ok  = i_ll_done && (cnt != '0);

  always_comb begin
    busy_nxt = busy_q;
    if (done_ok)
      busy_nxt[i_ll_done_reg] = 1'b0;
    // Set after clear so a same-cycle issue and done on one register leaves it busy.
    if (issue_ok && reg_nz(i_ll_issue_reg))
      busy_nxt[i_ll_issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      cnt    <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (issue_ok && !done_ok)
        cnt <= cnt + 1'b1;
      else if (!issue_ok && done_ok)
        cnt <= cnt - 1'b1;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/hazard_fwd_sb.sv
// Operand hazard and forwarding unit with long-latency scoreboard between RF read and issue.
// Latency: forwarding and o_hz_data are combinational (zero cycles); scoreboard updates next cycle.
// Backpressure: o_hz_data asks decode to stall; o_ll_full conservatively stalls any rd writer.
//
// Ports:
//   i_id_valid                decode holds a valid instruction (only gates the stall counter)
//   i_hz_rs1/rs2/rd, i_rs*    operand usage flags and register indices
//   i_rs*_raw_d               register-file read data
//   i_st_*                    per-stage writeback enable/dest/ready/data, stage 0 youngest
//   i_ll_issue*, i_ll_done*   long-latency commit and completion
//   o_rs*_d                   resolved operands
//   o_hz_data                 unrecoverable hazard
//   o_ll_full, o_sb_busy      scoreboard status
//   o_stall_cnt               stall cycle counter, present only with HAZARD_PERF_CNT_EN
//                             defined; tied to 0 otherwise
module hazard_fwd_sb
  import hazard_fwd_sb_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int LL_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_id_valid,
  input  logic                     i_hz_rs1,
  input  logic                     i_hz_rs2,
  input  logic                     i_hz_rd,
  input  logic [REG_AW-1:0]        i_rs1,
  input  logic [REG_AW-1:0]        i_rs2,
  input  logic [REG_AW-1:0]        i_rd,
  input  logic [XLEN-1:0]          i_rs1_raw_d,
  input  logic [XLEN-1:0]          i_rs2_raw_d,
  input  logic [STAGES-1:0]        i_st_wb_en,
  input  logic [REG_AW*STAGES-1:0] i_st_wb_reg,
  input  logic [STAGES-1:0]        i_st_fwd_ok,
  input  logic [XLEN*STAGES-1:0]   i_st_fwd_d,
  input  logic                     i_ll_issue,
  input  logic [REG_AW-1:0]        i_ll_issue_reg,
  input  logic                     i_ll_done,
  input  logic [REG_AW-1:0]        i_ll_done_reg,
  input  logic [XLEN-1:0]          i_ll_done_d,
  output logic [XLEN-1:0]          o_rs1_d,
  output logic [XLEN-1:0]          o_rs2_d,
  output logic                     o_hz_data,
  output logic                     o_ll_full,
  output logic [NREGS-1:0]         o_sb_busy,
  output logic [CNT_W-1:0]         o_stall_cnt
);

  logic [NREGS-1:0] busy;
  logic             ll_full;
  opnd_res_t        res1;
  opnd_res_t        res2;
  logic             rd_hz;

  hazard_scoreboard #(
    .LL_DEPTH (LL_DEPTH)
  ) u_sb (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_ll_issue     (i_ll_issue),
    .i_ll_issue_reg (i_ll_issue_reg),
    .i_ll_done      (i_ll_done),
    .i_ll_done_reg  (i_ll_done_reg),
    .o_busy         (busy),
    .o_full         (ll_full)
  );

  // Youngest matching stage decides alone (forward or stall); only when no stage
  // matches do the same-cycle completion bypass and then the scoreboard apply.
  function automatic opnd_res_t resolve(
    input logic                     en,
    input logic [REG_AW-1:0]        rs,
    input logic [XLEN-1:0]          raw,
    input logic [STAGES-1:0]        wb_en,
    input logic [REG_AW*STAGES-1:0] wb_reg,
    input logic [STAGES-1:0]        fwd_ok,
    input logic [XLEN*STAGES-1:0]   fwd_d,
    input logic                     done,
    input logic [REG_AW-1:0]        done_reg,
    input logic [XLEN-1:0]          done_d,
    input logic [NREGS-1:0]         sb_busy
  );
    opnd_res_t r;
    logic      hit;
    r.d  = raw;
    r.hz = 1'b0;
    hit  = 1'b0;
    if (en) begin
      for (int k = STAGE_YOUNGEST; k < STAGES; k++) begin
        if (!hit && wb_en[k] && (wb_reg[REG_AW*k +: REG_AW] == rs)) begin
          hit = 1'b1;
          if (fwd_ok[k])
            r.d = fwd_d[XLEN*k +: XLEN];
          else
            r.hz = 1'b1;
        end
      end
      if (!hit) begin
        if (done && (done_reg == rs))
          r.d = done_d;
        else if (sb_busy[rs])
          r.hz = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    res1 = resolve(i_hz_rs1 && reg_nz(i_rs1), i_rs1, i_rs1_raw_d, i_st_wb_en, i_st_wb_reg,
                   i_st_fwd_ok, i_st_fwd_d, i_ll_done, i_ll_done_reg, i_ll_done_d, busy);
    res2 = resolve(i_hz_rs2 && reg_nz(i_rs2), i_rs2, i_rs2_raw_d, i_st_wb_en, i_st_wb_reg,
                   i_st_fwd_ok, i_st_fwd_d, i_ll_done, i_ll_done_reg, i_ll_done_d, busy);
  end

  // WAW against an outstanding long-latency write, unless it retires this cycle.
  // Full also stalls any rd writer since we cannot tell whether it is long-latency.
  assign rd_hz = (i_hz_rd && reg_nz(i_rd) && busy[i_rd] &&
                  !(i_ll_done && (i_ll_done_reg == i_rd))) ||
                 (i_hz_rd && ll_full);

  assign o_rs1_d   = res1.d;
  assign o_rs2_d   = res2.d;
  assign o_hz_data = res1.hz || res2.hz || rd_hz;
  assign o_ll_full = ll_full;
  assign o_sb_busy = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (i_id_valid && o_hz_data && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_stall_cnt = stall_cnt;
`else
  logic unused_id_valid;
  assign unused_id_valid = i_id_valid;
  assign o_stall_cnt     = '0;
`endif

endmodule
